// File: rtl/uart_cmd_decode.sv
// UART 8N1 receiver feeding a write/read command decoder for the SDRAM test path.
// Write frames stream data bytes to the write FIFO, then pulse wr_trig.
module uart_cmd_decode #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115200,
    parameter int         BAUD_CNT = CLK_FREQ / BAUD,
    parameter logic [7:0] WR_CMD   = 8'h55,
    parameter logic [7:0] RD_CMD   = 8'hAA,
    parameter int         WR_LEN   = 4
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       po_flag,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wr_trig,
    output logic       rd_trig
);

    localparam int CW = $clog2(BAUD_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(BAUD_CNT / 2 - 1);

    typedef enum logic {
        IDLE,
        WR_DATA
    } state_t;

    logic          rx1, rx2, rx3;
    logic          rx_busy;
    logic          rx_done;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shift;

    state_t        state, next_state;
    logic [2:0]    cnt, next_cnt;
    logic          next_wr, next_rd, next_last;
    logic          wr_last;

    logic start_edge;
    assign start_edge = rx3 & ~rx2;

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            rx1      <= 1'b0;
            rx2      <= 1'b0;
            rx3      <= 1'b0;
            rx_busy  <= 1'b0;
            rx_done  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            po_flag  <= 1'b0;
        end else begin
            rx1     <= rs232_rx;
            rx2     <= rx1;
            rx3     <= rx2;
            rx_done <= 1'b0;
            po_flag <= rx_done;
            if (rx_done)
                rx_data <= shift;
            if (!rx_busy) begin
                baud_cnt <= '0;
                bit_idx  <= '0;
                if (start_edge)
                    rx_busy <= 1'b1;
            end else begin
                baud_cnt <= (baud_cnt == CNT_LAST) ? '0 : baud_cnt + 1'b1;
                if (baud_cnt == CNT_MID) begin
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd0) begin
                        // a high start-bit sample means the edge was a glitch
                        if (rx3)
                            rx_busy <= 1'b0;
                    end else begin
                        shift <= {rx3, shift[7:1]};
                        if (bit_idx == 4'd8) begin
                            rx_busy <= 1'b0;
                            rx_done <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_wr    = 1'b0;
        next_rd    = 1'b0;
        next_last  = 1'b0;
        if (po_flag) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == WR_CMD) begin
                        next_state = WR_DATA;
                        next_cnt   = 3'd0;
                    end else if (rx_data == RD_CMD) begin
                        next_rd = 1'b1;
                    end
                end
                WR_DATA: begin
                    next_wr  = 1'b1;
                    next_cnt = cnt + 3'd1;
                    if (cnt == 3'(WR_LEN - 1)) begin
                        next_state = IDLE;
                        next_cnt   = 3'd0;
                        next_last  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            wfifo_wr_en <= 1'b0;
            wfifo_data  <= '0;
            rd_trig     <= 1'b0;
            wr_last     <= 1'b0;
            wr_trig     <= 1'b0;
        end else begin
            state       <= next_state;
            cnt         <= next_cnt;
            wfifo_wr_en <= next_wr;
            rd_trig     <= next_rd;
            wr_last     <= next_last;
            wr_trig     <= wr_last;
            if (next_wr)
                wfifo_data <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Randomised self-checking bench for uart_cmd_decode against a frame-level model.
// A faster baud rate keeps each byte short in simulation.
module tb_uart_cmd_decode;

    localparam int BC     = 32;
    localparam int WR_LEN = 4;

    typedef logic [7:0] byte_q [$];

    logic       sclk = 1'b0;
    logic       reset = 1'b0;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       po_flag;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_data;
    logic       wr_trig;
    logic       rd_trig;

    uart_cmd_decode #(
        .CLK_FREQ(50_000_000),
        .BAUD    (1_562_500),
        .WR_CMD  (8'h55),
        .RD_CMD  (8'hAA),
        .WR_LEN  (WR_LEN)
    ) dut (
        .sclk       (sclk),
        .reset      (reset),
        .rs232_rx   (rs232_rx),
        .rx_data    (rx_data),
        .po_flag    (po_flag),
        .wfifo_wr_en(wfifo_wr_en),
        .wfifo_data (wfifo_data),
        .wr_trig    (wr_trig),
        .rd_trig    (rd_trig)
    );

    always #10 sclk = ~sclk;

    int n_tests = 0;
    int n_fail  = 0;

    // observed traffic, appended only by the monitor
    byte_q      po_q;
    byte_q      wr_q;
    int         rd_n = 0;
    int         wt_n = 0;
    int         lat_bad = 0;
    logic       po_d = 1'b0;
    logic       wr_d = 1'b0;
    logic [7:0] last_wd = 8'h00;

    always @(negedge sclk) begin
        if (reset) begin
            if (po_flag) begin
                po_q.push_back(rx_data);
                if (po_d) lat_bad++;
            end
            if (wfifo_wr_en) begin
                wr_q.push_back(wfifo_data);
                if (!po_d) lat_bad++;
            end else if (wfifo_data !== last_wd) begin
                lat_bad++;
            end
            if (rd_trig) begin
                rd_n++;
                if (!po_d) lat_bad++;
            end
            if (wr_trig) begin
                wt_n++;
                if (!wr_d) lat_bad++;
            end
        end
        po_d    = po_flag;
        wr_d    = wfifo_wr_en;
        last_wd = wfifo_data;
    end

    // frame-level reference model
    byte_q exp_po;
    byte_q exp_wr;
    int    exp_rd;
    int    exp_wt;
    bit    m_frame = 1'b0;
    int    m_cnt = 0;
    int    b_po, b_wr, b_rd, b_wt, b_lat;

    task automatic model_byte(input logic [7:0] b);
        exp_po.push_back(b);
        if (!m_frame) begin
            if (b == 8'h55) begin
                m_frame = 1'b1;
                m_cnt   = 0;
            end else if (b == 8'hAA) begin
                exp_rd++;
            end
        end else begin
            exp_wr.push_back(b);
            m_cnt++;
            if (m_cnt == WR_LEN) begin
                exp_wt++;
                m_frame = 1'b0;
            end
        end
    endtask

    task automatic begin_test();
        exp_po.delete();
        exp_wr.delete();
        exp_rd = 0;
        exp_wt = 0;
        b_po  = po_q.size();
        b_wr  = wr_q.size();
        b_rd  = rd_n;
        b_wt  = wt_n;
        b_lat = lat_bad;
    endtask

    function automatic int q_diff(byte_q got, int base, byte_q want);
        if (got.size() - base != want.size()) return -2;
        for (int i = 0; i < want.size(); i++)
            if (got[base + i] !== want[i]) return i;
        return -1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge sclk);
        rs232_rx = 1'b0;
        repeat (BC) @(negedge sclk);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            repeat (BC) @(negedge sclk);
        end
        rs232_rx = 1'b1;
        repeat (BC - 1) @(negedge sclk);
        repeat (gap) @(negedge sclk);
        model_byte(b);
    endtask

    task automatic send_list(input byte_q bl, input int gap);
        foreach (bl[i]) send_byte(bl[i], gap);
        repeat (20) @(negedge sclk);
    endtask

    task automatic test_reset();
        #100;
        n_tests++;
        if ({rx_data, po_flag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs=%h want 0",
                     {rx_data, po_flag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig});
        end
        #101;
        reset = 1'b1;
        begin_test();
        repeat (60) @(negedge sclk);
        n_tests++;
        if (po_q.size() != b_po) begin
            n_fail++;
            $display("FAIL reset_idle_po: got %0d po_flag, want 0", po_q.size() - b_po);
        end
        n_tests++;
        if ({rx_data, po_flag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_idle_out: outputs=%h want 0",
                     {rx_data, po_flag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig});
        end
    endtask

    task automatic test_write_read();
        byte_q s;
        int d;
        begin_test();
        s = '{8'h55, 8'h12, 8'h34, 8'h56, 8'h78};
        send_list(s, 150);
        d = q_diff(wr_q, b_wr, exp_wr);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL write_data: got %0d writes, want %0d (diff %0d)",
                     wr_q.size() - b_wr, exp_wr.size(), d);
        end
        n_tests++;
        if (wt_n - b_wt != exp_wt || exp_wt != 1) begin
            n_fail++;
            $display("FAIL write_trig: got %0d wr_trig, want %0d", wt_n - b_wt, exp_wt);
        end
        s = '{8'hAA};
        send_list(s, 150);
        d = q_diff(po_q, b_po, exp_po);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL write_read_po: got %0d bytes, want %0d (diff %0d)",
                     po_q.size() - b_po, exp_po.size(), d);
        end
        n_tests++;
        if (rd_n - b_rd != exp_rd || wr_q.size() - b_wr != exp_wr.size()) begin
            n_fail++;
            $display("FAIL read_trig: got rd=%0d wr=%0d, want rd=%0d wr=%0d",
                     rd_n - b_rd, wr_q.size() - b_wr, exp_rd, exp_wr.size());
        end
    endtask

    task automatic test_repeat();
        byte_q s;
        int d;
        begin_test();
        s = '{8'h55, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA,
              8'h55, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA};
        send_list(s, 150);
        d = q_diff(wr_q, b_wr, exp_wr);
        n_tests++;
        if (d != -1 || wt_n - b_wt != exp_wt || rd_n - b_rd != exp_rd) begin
            n_fail++;
            $display("FAIL repeat: got wr=%0d wt=%0d rd=%0d, want wr=%0d wt=%0d rd=%0d (diff %0d)",
                     wr_q.size() - b_wr, wt_n - b_wt, rd_n - b_rd,
                     exp_wr.size(), exp_wt, exp_rd, d);
        end
    endtask

    task automatic test_cmd_as_data();
        byte_q s;
        int d;
        begin_test();
        s = '{8'h55, 8'hAA, 8'h55, 8'h01, 8'h02};
        send_list(s, 150);
        d = q_diff(wr_q, b_wr, exp_wr);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL cmd_as_data: got %0d writes, want %0d (diff %0d)",
                     wr_q.size() - b_wr, exp_wr.size(), d);
        end
        n_tests++;
        if (rd_n - b_rd != 0 || wt_n - b_wt != 1) begin
            n_fail++;
            $display("FAIL cmd_as_data_trig: got rd=%0d wt=%0d, want rd=0 wt=1",
                     rd_n - b_rd, wt_n - b_wt);
        end
    endtask

    task automatic test_stray_glitch();
        byte_q s;
        int d;
        begin_test();
        s = '{8'h3C};
        send_list(s, 150);
        @(negedge sclk);
        rs232_rx = 1'b0;
        repeat (5) @(negedge sclk);
        rs232_rx = 1'b1;
        repeat (3 * BC) @(negedge sclk);
        d = q_diff(po_q, b_po, exp_po);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL stray_glitch_po: got %0d bytes, want %0d (diff %0d)",
                     po_q.size() - b_po, exp_po.size(), d);
        end
        n_tests++;
        if (wr_q.size() != b_wr || rd_n != b_rd || wt_n != b_wt) begin
            n_fail++;
            $display("FAIL stray_glitch_out: got wr=%0d rd=%0d wt=%0d, want 0 0 0",
                     wr_q.size() - b_wr, rd_n - b_rd, wt_n - b_wt);
        end
    endtask

    task automatic test_reset_mid();
        byte_q s;
        int d;
        begin_test();
        s = '{8'h55, 8'h11, 8'h22};
        send_list(s, 150);
        // partial byte, then reset mid-transfer
        @(negedge sclk);
        rs232_rx = 1'b0;
        repeat (BC * 3 + 5) @(negedge sclk);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({rx_data, po_flag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_out: outputs=%h want 0",
                     {rx_data, po_flag, wfifo_wr_en, wfifo_data, wr_trig, rd_trig});
        end
        rs232_rx = 1'b1;
        m_frame  = 1'b0;
        repeat (4) @(negedge sclk);
        reset = 1'b1;
        repeat (12 * BC) @(negedge sclk);
        s = '{8'hAA};
        send_list(s, 150);
        d = q_diff(po_q, b_po, exp_po);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL reset_mid_po: got %0d bytes, want %0d (diff %0d)",
                     po_q.size() - b_po, exp_po.size(), d);
        end
        n_tests++;
        if (rd_n - b_rd != 1 || wr_q.size() - b_wr != 2 || wt_n != b_wt) begin
            n_fail++;
            $display("FAIL reset_mid_trig: got rd=%0d wr=%0d wt=%0d, want 1 2 0",
                     rd_n - b_rd, wr_q.size() - b_wr, wt_n - b_wt);
        end
    endtask

    task automatic test_back_to_back();
        byte_q s;
        int d;
        begin_test();
        s = '{8'h55};
        for (int i = 0; i < WR_LEN; i++) s.push_back(8'($urandom));
        s.push_back(8'hAA);
        s.push_back(8'h55);
        for (int i = 0; i < WR_LEN; i++) s.push_back(8'($urandom));
        send_list(s, 0);
        d = q_diff(wr_q, b_wr, exp_wr);
        n_tests++;
        if (d != -1 || q_diff(po_q, b_po, exp_po) != -1) begin
            n_fail++;
            $display("FAIL back_to_back: got po=%0d wr=%0d, want po=%0d wr=%0d (diff %0d)",
                     po_q.size() - b_po, wr_q.size() - b_wr,
                     exp_po.size(), exp_wr.size(), d);
        end
        n_tests++;
        if (rd_n - b_rd != exp_rd || wt_n - b_wt != exp_wt) begin
            n_fail++;
            $display("FAIL back_to_back_trig: got rd=%0d wt=%0d, want rd=%0d wt=%0d",
                     rd_n - b_rd, wt_n - b_wt, exp_rd, exp_wt);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        int d;
        begin_test();
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       b = 8'h55;
                1:       b = 8'hAA;
                default: b = 8'($urandom);
            endcase
            send_byte(b, $urandom_range(0, 20));
        end
        repeat (20) @(negedge sclk);
        d = q_diff(po_q, b_po, exp_po);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL random_po: got %0d bytes, want %0d (diff %0d)",
                     po_q.size() - b_po, exp_po.size(), d);
        end
        d = q_diff(wr_q, b_wr, exp_wr);
        n_tests++;
        if (d != -1) begin
            n_fail++;
            $display("FAIL random_wr: got %0d writes, want %0d (diff %0d)",
                     wr_q.size() - b_wr, exp_wr.size(), d);
        end
        n_tests++;
        if (rd_n - b_rd != exp_rd || wt_n - b_wt != exp_wt) begin
            n_fail++;
            $display("FAIL random_trig: got rd=%0d wt=%0d, want rd=%0d wt=%0d",
                     rd_n - b_rd, wt_n - b_wt, exp_rd, exp_wt);
        end
    endtask

    task automatic test_timing();
        n_tests++;
        if (lat_bad != 0) begin
            n_fail++;
            $display("FAIL pulse_timing: got %0d timing violations, want 0", lat_bad);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_repeat();
        test_cmd_as_data();
        test_stray_glitch();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_timing();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
